cmp_pipe: RTL and testbench

Parametrised, pipelined compare unit for the BETA datapath. It takes two operands and a compare function code, computes the Z/N/V/C flags internally, and returns a zero-extended boolean result. Both the flag stage and the result stage are registered, and a valid/ready handshake provides back-pressure. It supersedes the flag-driven combinational compare mux in the ALU. Function codes 0–3 keep their existing meaning; codes 4–6 add not-equal and unsigned compares.

---
 rtl/cmp_pkg.sv | 62 ++++++
 rtl/cmp_pipe_if.sv | 45 ++++
 rtl/cmp_flags.sv | 35 +++
 rtl/cmp_pipe.sv | 105 ++++++++++
 tb/tb_cmp_pipe.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the BETA compare pipeline.
//   - compare function codes (CFN_*)
//   - flag bit positions inside the 4-bit {Z,N,V,C} flag word
//   - stage-1 payload struct and the function-code decoder
package cmp_pkg;

    localparam int unsigned CFN_W   = 3;
    localparam int unsigned FLAGS_W = 4;

    typedef logic [CFN_W-1:0]   cfn_t;
    typedef logic [FLAGS_W-1:0] flags_t;

    // Function codes; 0-3 match the legacy ALU compare mux
    localparam cfn_t CFN_NONE = 3'd0;
    localparam cfn_t CFN_EQ   = 3'd1;
    localparam cfn_t CFN_LT   = 3'd2;
    localparam cfn_t CFN_LE   = 3'd3;
    localparam cfn_t CFN_NE   = 3'd4;
    localparam cfn_t CFN_LTU  = 3'd5;
    localparam cfn_t CFN_LEU  = 3'd6;
    localparam cfn_t CFN_RSVD = 3'd7;

    // Flag word layout: {Z,N,V,C}
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    // Payload held in stage 1 between flag generation and decode
    typedef struct packed {
        flags_t flags;
        cfn_t   cfn;
    } s1_t;

    // Boolean compare result for a function code and a flag word.
    // C=1 means "no borrow", so unsigned a<b is ~C.
    function automatic logic cfn_eval(input cfn_t cfn, input flags_t f);
        logic z;
        logic n;
        logic v;
        logic c;
        logic r;
        z = f[FLAG_Z];
        n = f[FLAG_N];
        v = f[FLAG_V];
        c = f[FLAG_C];
        r = 1'b0;
        case (cfn)
            CFN_NONE: r = 1'b0;
            CFN_EQ:   r = z;
            CFN_LT:   r = n ^ v;
            CFN_LE:   r = z | (n ^ v);
            CFN_NE:   r = ~z;
            CFN_LTU:  r = ~c;
            CFN_LEU:  r = z | ~c;
            CFN_RSVD: r = 1'b0;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_pipe_if.sv
// Operand/result bundle of the compare pipeline.
//   in side : in_valid, in_ready, a, b, cfn
//   out side: out_valid, out_ready, y, flags
// slave  : the compare unit (consumes operands, produces results)
// master : the producer/consumer around it
interface cmp_pipe_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OUT_WIDTH = 32
);

    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    cmp_pkg::cfn_t         cfn;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  y;
    cmp_pkg::flags_t       flags;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cfn,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output flags
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output cfn,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  flags
    );

endinterface

// File: rtl/cmp_flags.sv
// Combinational subtractor plus {Z,N,V,C} flag generator.
//   a_i, b_i  : operands (WIDTH bits)
//   flags_c_o : {Z,N,V,C} of a - b, combinational
// The difference is formed WIDTH+1 bits wide so the top bit is the
// carry-out (C=1 means no borrow). Reusable by the ALU adder path.
module cmp_flags
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output flags_t           flags_c_o
);

    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned MSB   = WIDTH - 1;

    logic [SUM_W-1:0] d_c;

    // a + ~b + 1 == a - b with carry-out in the extra bit
    always_comb begin
        d_c = {1'b0, a_i} + {1'b0, ~b_i} + SUM_W'(1);
    end

    // Overflow: operand signs differ and the result sign differs from a
    always_comb begin
        flags_c_o         = '0;
        flags_c_o[FLAG_Z] = (d_c[MSB:0] == '0);
        flags_c_o[FLAG_N] = d_c[MSB];
        flags_c_o[FLAG_V] = (a_i[MSB] != b_i[MSB]) && (d_c[MSB] != a_i[MSB]);
        flags_c_o[FLAG_C] = d_c[WIDTH];
    end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage pipelined compare unit with valid/ready back-pressure.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : cmp_pipe_if slave (operands in, {0..,result} + flags out)
// S1 registers the flags of a-b and the function code; S2 decodes the
// function code and registers y/flags. in_ready is the only
// combinational output (it depends on out_ready).
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    cmp_pipe_if.slave  bus
);

    logic                 v1_q;
    logic                 v1_d;
    s1_t                  s1_q;
    s1_t                  s1_d;
    logic                 v2_q;
    logic                 v2_d;
    logic [OUT_WIDTH-1:0] y_q;
    logic [OUT_WIDTH-1:0] y_d;
    flags_t               flags_q;
    flags_t               flags_d;

    flags_t               flags_c;
    logic                 adv2_c;
    logic                 in_ready_c;
    logic                 acc1_c;
    logic                 res_c;

    // Flag generation for the operands currently on the bus
    cmp_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .a_i       (bus.a),
        .b_i       (bus.b),
        .flags_c_o (flags_c)
    );

    // Handshake: S2 takes S1 when S2 is empty or being drained;
    // S1 can take new operands when empty or moving into S2.
    always_comb begin
        adv2_c     = v1_q && (!v2_q || bus.out_ready);
        in_ready_c = !v1_q || adv2_c;
        acc1_c     = bus.in_valid && in_ready_c;
    end

    // Function decode on the registered S1 flags
    always_comb begin
        res_c = cfn_eval(s1_q.cfn, s1_q.flags);
    end

    // Next-state for both stages; stalled stages hold their contents
    always_comb begin
        v1_d    = v1_q;
        s1_d    = s1_q;
        v2_d    = v2_q;
        y_d     = y_q;
        flags_d = flags_q;

        if (acc1_c) begin
            v1_d       = 1'b1;
            s1_d.flags = flags_c;
            s1_d.cfn   = bus.cfn;
        end else if (adv2_c) begin
            v1_d = 1'b0;
        end

        if (adv2_c) begin
            v2_d    = 1'b1;
            y_d     = OUT_WIDTH'(res_c);
            flags_d = s1_q.flags;
        end else if (v2_q && bus.out_ready) begin
            v2_d = 1'b0;
        end
    end

    // Stage registers; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            s1_q    <= '0;
            v2_q    <= 1'b0;
            y_q     <= '0;
            flags_q <= '0;
        end else begin
            v1_q    <= v1_d;
            s1_q    <= s1_d;
            v2_q    <= v2_d;
            y_q     <= y_d;
            flags_q <= flags_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = v2_q;
    assign bus.y         = y_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: a 32-bit and an 8-bit/1-bit instance
// share clock and reset. Directed vector tables with hand-computed
// results, plus hand-written back-pressure and reset sequences.
module tb_cmp_pipe;
    import cmp_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmp_pipe_if #(.WIDTH(32), .OUT_WIDTH(32)) bus32 ();
    cmp_pipe_if #(.WIDTH(8),  .OUT_WIDTH(1))  bus8 ();

    cmp_pipe #(.WIDTH(32), .OUT_WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    cmp_pipe #(.WIDTH(8), .OUT_WIDTH(1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cfn;
        logic [31:0] y;
        logic [3:0]  f;
    } vec_t;

    vec_t v32 [13];
    vec_t v8  [4];
    vec_t bp  [3];
    vec_t idle;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t get_vec(input bit narrow, input int i);
        if (narrow) return v8[i];
        return v32[i];
    endfunction

    task automatic drive(input bit narrow, input logic vld, input vec_t v);
        if (narrow) begin
            bus8.in_valid = vld;
            bus8.a        = v.a[7:0];
            bus8.b        = v.b[7:0];
            bus8.cfn      = v.cfn;
        end else begin
            bus32.in_valid = vld;
            bus32.a        = v.a;
            bus32.b        = v.b;
            bus32.cfn      = v.cfn;
        end
    endtask

    task automatic sample(input bit narrow, output logic ir, output logic ov,
                          output logic [31:0] y, output logic [3:0] f);
        if (narrow) begin
            ir = bus8.in_ready;
            ov = bus8.out_valid;
            y  = 32'(bus8.y);
            f  = bus8.flags;
        end else begin
            ir = bus32.in_ready;
            ov = bus32.out_valid;
            y  = bus32.y;
            f  = bus32.flags;
        end
    endtask

    // Back-to-back stream with out_ready=1: vector t is driven in cycle t
    // and its result must be on the outputs in cycle t+2.
    task automatic run_stream(input bit narrow, input int n);
        logic        ir;
        logic        ov;
        logic [31:0] y;
        logic [3:0]  f;
        vec_t        ev;
        for (int t = 0; t < n + 2; t++) begin
            sample(narrow, ir, ov, y, f);
            chk($sformatf("s%0d[%0d] in_ready", narrow, t), 32'(ir), 32'd1);
            if (t >= 2) begin
                ev = get_vec(narrow, t - 2);
                chk($sformatf("s%0d[%0d] out_valid", narrow, t - 2), 32'(ov), 32'd1);
                chk($sformatf("s%0d[%0d] y", narrow, t - 2), y, ev.y);
                chk($sformatf("s%0d[%0d] flags", narrow, t - 2), 32'(f), 32'(ev.f));
            end else begin
                chk($sformatf("s%0d[%0d] early out_valid", narrow, t), 32'(ov), 32'd0);
            end
            if (t < n) drive(narrow, 1'b1, get_vec(narrow, t));
            else       drive(narrow, 1'b0, idle);
            tick();
        end
    endtask

    initial begin
        logic        ir;
        logic        ov;
        logic [31:0] y;
        logic [3:0]  f;
        int          idx;
        int          got;
        int          cyc;

        idle = '{a: 32'd0, b: 32'd0, cfn: CFN_NONE, y: 32'd0, f: 4'b0000};

        // 32-bit vectors: flags are {Z,N,V,C} of a-b
        v32[0]  = '{a: 32'd5,          b: 32'd5,          cfn: CFN_EQ,   y: 32'd1, f: 4'b1001};
        v32[1]  = '{a: 32'hFFFF_FFFF,  b: 32'd1,          cfn: CFN_LT,   y: 32'd1, f: 4'b0101};
        v32[2]  = '{a: 32'hFFFF_FFFF,  b: 32'd1,          cfn: CFN_LTU,  y: 32'd0, f: 4'b0101};
        v32[3]  = '{a: 32'd3,          b: 32'd7,          cfn: CFN_LEU,  y: 32'd1, f: 4'b0100};
        v32[4]  = '{a: 32'h8000_0000,  b: 32'd1,          cfn: CFN_LT,   y: 32'd1, f: 4'b0011};
        v32[5]  = '{a: 32'h8000_0000,  b: 32'd1,          cfn: CFN_LE,   y: 32'd1, f: 4'b0011};
        v32[6]  = '{a: 32'd5,          b: 32'd5,          cfn: CFN_NONE, y: 32'd0, f: 4'b1001};
        v32[7]  = '{a: 32'd3,          b: 32'd7,          cfn: CFN_RSVD, y: 32'd0, f: 4'b0100};
        v32[8]  = '{a: 32'd5,          b: 32'd5,          cfn: CFN_NE,   y: 32'd0, f: 4'b1001};
        v32[9]  = '{a: 32'd3,          b: 32'd7,          cfn: CFN_NE,   y: 32'd1, f: 4'b0100};
        v32[10] = '{a: 32'd0,          b: 32'd1,          cfn: CFN_LTU,  y: 32'd1, f: 4'b0100};
        v32[11] = '{a: 32'd7,          b: 32'd3,          cfn: CFN_LE,   y: 32'd0, f: 4'b0001};
        v32[12] = '{a: 32'h7FFF_FFFF,  b: 32'hFFFF_FFFF,  cfn: CFN_LT,   y: 32'd0, f: 4'b0110};

        // 8-bit operands, 1-bit result
        v8[0] = '{a: 32'h7F, b: 32'h80, cfn: CFN_LT,  y: 32'd0, f: 4'b0110};
        v8[1] = '{a: 32'h7F, b: 32'h80, cfn: CFN_LTU, y: 32'd1, f: 4'b0110};
        v8[2] = '{a: 32'h80, b: 32'h7F, cfn: CFN_LT,  y: 32'd1, f: 4'b0011};
        v8[3] = '{a: 32'hFF, b: 32'hFF, cfn: CFN_EQ,  y: 32'd1, f: 4'b1001};

        // Back-pressure items
        bp[0] = '{a: 32'd5, b: 32'd5, cfn: CFN_EQ,  y: 32'd1, f: 4'b1001};
        bp[1] = '{a: 32'd7, b: 32'd3, cfn: CFN_LE,  y: 32'd0, f: 4'b0001};
        bp[2] = '{a: 32'd3, b: 32'd7, cfn: CFN_LEU, y: 32'd1, f: 4'b0100};

        // Reset held 3 cycles with in_valid=1: nothing must appear
        rst_n            = 1'b0;
        bus32.out_ready  = 1'b1;
        bus8.out_ready   = 1'b1;
        drive(1'b0, 1'b1, v32[0]);
        drive(1'b1, 1'b1, v8[3]);
        for (int c = 0; c < 3; c++) begin
            tick();
            sample(1'b0, ir, ov, y, f);
            chk($sformatf("rst[%0d] out_valid", c), 32'(ov), 32'd0);
            chk($sformatf("rst[%0d] y", c), y, 32'd0);
            chk($sformatf("rst[%0d] flags", c), 32'(f), 32'd0);
        end
        sample(1'b1, ir, ov, y, f);
        chk("rst8 out_valid", 32'(ov), 32'd0);
        chk("rst8 y", y, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, idle);
        drive(1'b1, 1'b0, idle);
        tick();
        sample(1'b0, ir, ov, y, f);
        chk("post-rst in_ready", 32'(ir), 32'd1);
        chk("post-rst out_valid", 32'(ov), 32'd0);

        // Streams
        run_stream(1'b0, 13);
        run_stream(1'b1, 4);
        tick();
        tick();

        // Back-pressure: out_ready low for 5 cycles, in_valid held high
        bus32.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            sample(1'b0, ir, ov, y, f);
            if (c >= 2) begin
                chk($sformatf("bp stall[%0d] y", c), y, bp[0].y);
                chk($sformatf("bp stall[%0d] flags", c), 32'(f), 32'(bp[0].f));
            end
            drive(1'b0, 1'b1, bp[idx]);
            if (ir) idx++;
            tick();
        end
        sample(1'b0, ir, ov, y, f);
        chk("bp accepted", 32'(idx), 32'd2);
        chk("bp in_ready", 32'(ir), 32'd0);
        chk("bp out_valid", 32'(ov), 32'd1);
        chk("bp y", y, bp[0].y);

        // Release: exactly bp[0], bp[1] in order, no duplicates
        drive(1'b0, 1'b0, idle);
        bus32.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 6; c++) begin
            sample(1'b0, ir, ov, y, f);
            if (ov) begin
                if (got < 2) begin
                    chk($sformatf("bp drain[%0d] y", got), y, bp[got].y);
                    chk($sformatf("bp drain[%0d] flags", got), 32'(f), 32'(bp[got].f));
                end else begin
                    chk("bp drain extra out_valid", 32'(ov), 32'd0);
                end
                got++;
            end
            tick();
        end
        chk("bp drain count", 32'(got), 32'd2);

        // Reset with both stages full
        bus32.out_ready = 1'b0;
        drive(1'b0, 1'b1, bp[0]);
        cyc = 0;
        do begin
            tick();
            sample(1'b0, ir, ov, y, f);
            cyc++;
        end while (ir && cyc < 10);
        chk("full in_ready", 32'(ir), 32'd0);
        chk("full out_valid", 32'(ov), 32'd1);
        drive(1'b0, 1'b0, idle);
        rst_n = 1'b0;
        tick();
        sample(1'b0, ir, ov, y, f);
        chk("midrst out_valid", 32'(ov), 32'd0);
        chk("midrst y", y, 32'd0);
        chk("midrst flags", 32'(f), 32'd0);
        rst_n = 1'b1;
        bus32.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            sample(1'b0, ir, ov, y, f);
            chk($sformatf("midrst after[%0d] out_valid", c), 32'(ov), 32'd0);
            chk($sformatf("midrst after[%0d] in_ready", c), 32'(ir), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
